// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin core/DMA arbiter for a single memory port with DMA burst lock and per-transaction timeout
module mem_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int TIMEOUT = 16,
  parameter int MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          core_req,
  input  logic          core_we,
  input  logic [AW-1:0] core_addr,
  input  logic [DW-1:0] core_wdata,
  output logic [DW-1:0] core_rdata,
  output logic          core_ack,
  output logic          core_err,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  input  logic          dma_lock,
  output logic [DW-1:0] dma_rdata,
  output logic          dma_ack,
  output logic          dma_err,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic          busy
);
  localparam logic [1:0] IDLE = 2'd0, BUSY_CORE = 2'd1, BUSY_DMA = 2'd2;
  localparam int TW = $clog2(TIMEOUT);
  localparam int BW = $clog2(MAX_BURST + 1);
  logic [1:0] state_q, state_d;
  logic last_grant_q, last_grant_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [BW-1:0] burst_q, burst_d;
  logic is_core, is_dma, tmo_hit, done, keep, pick_core, any_req;
  always_comb begin
    is_core = state_q == BUSY_CORE;
    is_dma = state_q == BUSY_DMA;
    busy = is_core | is_dma;
    tmo_hit = busy && tmo_q == TW'(TIMEOUT - 1) && !mem_ack;
    done = busy && (mem_ack || tmo_hit);
    core_ack = is_core && done;
    core_err = is_core && tmo_hit;
    dma_ack = is_dma && done;
    dma_err = is_dma && tmo_hit;
    core_rdata = mem_rdata;
    dma_rdata = mem_rdata;
    mem_req = busy;
    mem_we = is_core ? core_we : is_dma ? dma_we : 1'b0;
    mem_addr = is_core ? core_addr : is_dma ? dma_addr : '0;
    mem_wdata = is_core ? core_wdata : is_dma ? dma_wdata : '0;
    // last_grant 1 means DMA won last, so a tie goes to the core
    any_req = core_req || dma_req;
    pick_core = core_req && (!dma_req || last_grant_q);
    keep = is_dma && mem_ack && dma_lock && (!core_req || burst_q < BW'(MAX_BURST - 1));
    state_d = !busy ? (any_req ? (pick_core ? BUSY_CORE : BUSY_DMA) : IDLE) : (done && !keep) ? IDLE : state_q;
    last_grant_d = (!busy && any_req) ? !pick_core : last_grant_q;
    tmo_d = (!busy || done) ? '0 : tmo_q + 1'b1;
    // burst count saturates so a long unopposed burst still yields as soon as the core asks
    burst_d = keep ? (burst_q < BW'(MAX_BURST - 1) ? burst_q + 1'b1 : burst_q) : (!busy || done) ? '0 : burst_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      last_grant_q <= 1'b1;
      tmo_q <= '0;
      burst_q <= '0;
    end else begin
      state_q <= state_d;
      last_grant_q <= last_grant_d;
      tmo_q <= tmo_d;
      burst_q <= burst_d;
    end
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbitrates the multi-cycle processor's single unified memory port between the core and a DMA/loader requester. Each transaction is a request/acknowledge handshake. The block selects one requester with round-robin priority, steers address/data/write-enable to memory, and returns the memory acknowledge to the winner. A DMA can lock the port for short bursts, capped so the core cannot starve. A per-transaction watchdog aborts any access the memory never acknowledges.

## Interface
- AW, 32, address width
- DW, 32, data width
- TIMEOUT, 16, max busy cycles per transaction before abort (≥2)
- MAX_BURST, 4, max consecutive locked DMA transactions while core waits (≥1)

- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-high
- core_req  in  1  core request, held until core_ack
- core_we  in  1  core write enable
- core_addr  in  AW  core address
- core_wdata  in  DW  core write data
- core_rdata  out  DW  read data (= mem_rdata)
- core_ack  out  1  core transaction complete, 1-cycle pulse
- core_err  out  1  core transaction aborted by timeout, concurrent with core_ack
- dma_req, dma_we, dma_addr, dma_wdata  in  1/1/AW/DW  DMA request fields, same rules as core
- dma_lock  in  1  sampled on dma_ack cycle: keep grant for next DMA transaction
- dma_rdata  out  DW  read data (= mem_rdata)
- dma_ack, dma_err  out  1/1  as core
- mem_req  out  1  transaction valid to memory
- mem_we  out  1  write enable
- mem_addr  out  AW  address
- mem_wdata  out  DW  write data
- mem_rdata  in  DW  read data, valid with mem_ack
- mem_ack  in  1  memory completion, any latency ≥0 cycles after mem_req rises
- busy  out  1  state ≠ IDLE

## Operation
- States: IDLE, BUSY_CORE, BUSY_DMA. Registers: state, last_grant (CORE/DMA), tmo_cnt, burst_cnt.
- IDLE: only core_req → BUSY_CORE. Only dma_req → BUSY_DMA. Both → grant the port ≠ last_grant. Neither → stay.
- On entering BUSY_x: last_grant←x, tmo_cnt←0.
- BUSY_x: mem_req=1. mem_we/addr/wdata combinationally muxed from port x. x_ack=mem_ack; other port's ack=0.
- Outside BUSY: mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
- Ack cycle in BUSY_CORE → IDLE.
- Ack cycle in BUSY_DMA:
  - dma_lock=1 and (core_req=0 or burst_cnt<MAX_BURST-1) → stay BUSY_DMA, burst_cnt+1, tmo_cnt←0. The memory treats the next cycle with mem_req high as a new transaction. DMA presents the new request that cycle.
  - Otherwise → IDLE, burst_cnt←0.
- Requester's req may drop, or be re-presented as a new request, only after its ack. The acked port's req in the ack cycle is ignored.
- Timeout: tmo_cnt increments on each BUSY cycle without mem_ack. If tmo_cnt==TIMEOUT-1 and mem_ack=0: assert x_ack and x_err that cycle, go IDLE, burst_cnt←0.
- mem_ack and timeout in the same cycle → normal ack, err=0.
- core_rdata and dma_rdata always equal mem_rdata; meaningful only with the respective ack.

## Timing
- Reset (synchronous): state=IDLE, last_grant=DMA (core wins the first tie), tmo_cnt=0, burst_cnt=0.
- After reset, all outputs are 0 except the rdata buses, which follow mem_rdata.
- Reset mid-transaction: mem_req low the cycle after the reset edge, no ack/err issued.
- Request seen in IDLE at cycle N → mem_req high from cycle N+1.
- With zero-latency memory (mem_ack in N+1), x_ack is in N+1 and the next grant is possible at N+3. That gives a 1-cycle IDLE bubble between unlocked transactions.
- Locked DMA burst has no bubble: mem_req stays high, one transaction per ack.
- Timeout abort occurs in the TIMEOUT-th BUSY cycle.
- Ack/err are combinational from mem_ack and state. No registered output latency.

## Test plan
- Lone core read of addr 0x40, memory acks 2 cycles after mem_req with 0xDEADBEEF:
  - mem_addr=0x40 and mem_we=0 throughout.
  - core_ack=1 with core_rdata=0xDEADBEEF.
  - dma_ack stays 0, busy falls the next cycle.
- Core and DMA request together right after reset, each held continuously: grants alternate CORE, DMA, CORE, DMA across 4 transactions.
- DMA write, memory never acks, TIMEOUT=16:
  - dma_ack=dma_err=1 in the 16th busy cycle, mem_req low the next cycle.
  - A core request then proceeds normally.
  - Repeat with mem_ack arriving exactly in the 16th cycle → dma_err=0.
- DMA with dma_lock=1 for 10 transactions, core_req rising mid-burst, MAX_BURST=4:
  - At most 4 DMA transactions (counting from burst start) before IDLE, then the core is granted.
  - With core_req=0 throughout, all 10 run back-to-back with no bubble.
- Reset asserted during BUSY_CORE before mem_ack:
  - No core_ack.
  - mem_req=0 and state IDLE next cycle.
  - First subsequent tie goes to core.
- Zero-latency memory (mem_ack same cycle as mem_req), two queued core reads: grants at N+1 and N+3, acks at N+1 and N+3.
